// File: rtl/pmem_responder.sv
// Memory-side responder for the cache hierarchy's pmem port.
// Requests are captured in IDLE, answered after a fixed latency with an
// 8-beat read burst or a single write/error acknowledge, then a GAP cycle
// lets the requester drop its request before the next one is accepted.
module pmem_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned LINES   = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic         pmem_resp,
    output logic         pmem_error,
    output logic [31:0]  pmem_rdata
);

    localparam int unsigned IDXW     = $clog2(LINES);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RBURST,
        S_WACK,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        beat_q, beat_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [255:0]      wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              err_q, err_d;
    logic              addr_oor;
    logic              commit;

    // Line storage; deliberately not reset so contents survive rst.
    logic [255:0]      mem [LINES];

    // Any address bit above the line index makes the request out of range.
    always_comb begin
        addr_oor = (pmem_address >> (5 + IDXW)) != '0;
    end

    // State and captured-request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; request inputs are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (pmem_read || pmem_write) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                    beat_d  = '0;
                    idx_d   = pmem_address[5 +: IDXW];
                    wdata_d = pmem_wdata;
                    rd_d    = pmem_read;
                    err_d   = addr_oor || (pmem_read && pmem_write);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = (rd_q && !err_q) ? S_RBURST : S_WACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RBURST: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == 3'd7) begin
                    state_d = S_GAP;
                end
            end
            S_WACK:  state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response outputs, decoded purely from registered state so reset clears them at once.
    always_comb begin
        pmem_resp  = 1'b0;
        pmem_error = 1'b0;
        pmem_rdata = '0;
        commit     = 1'b0;
        case (state_q)
            S_RBURST: begin
                pmem_resp  = 1'b1;
                pmem_rdata = mem[idx_q][{beat_q, 5'b0} +: 32];
            end
            S_WACK: begin
                pmem_resp  = 1'b1;
                pmem_error = err_q;
                commit     = !rd_q && !err_q;
            end
            default: ;
        endcase
    end

    // A valid write lands in storage on the edge that ends its WACK cycle.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder with LATENCY=4, LINES=64.
module tb_pmem_responder;

    localparam int LAT   = 4;
    localparam int FIRST = LAT + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic         pmem_error;
    logic [31:0]  pmem_rdata;

    int total = 0;
    int bad   = 0;
    int n;

    logic [255:0] l0, l2, l2_new, l5, junk;

    pmem_responder #(.LATENCY(LAT), .LINES(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_error   (pmem_error),
        .pmem_rdata   (pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mkline(input logic [31:0] a, input logic [31:0] d);
        logic [255:0] w;
        for (int unsigned k = 0; k < 8; k++) begin
            w[k*32 +: 32] = a + 32'(k) * d;
        end
        return w;
    endfunction

    // Called at a negedge. Drives a request, scrambles address/data once the
    // request should be captured, and checks every response beat and idle cycle
    // up to and including the GAP cycle. Returns at the GAP negedge.
    task automatic xact(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wd, input int nbeats, input logic eerr,
                        input logic [255:0] eline, input int first_cyc,
                        input logic hold, input string tag);
        int   beats = 0;
        logic done  = 1'b0;
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == first_cyc - LAT + 1) begin
                pmem_address = ~addr;
                pmem_wdata   = ~wd;
            end
            if (pmem_resp) begin
                if (beats == 0) chk($sformatf("%s_first", tag), 32'(cyc), 32'(first_cyc));
                chk($sformatf("%s_err%0d", tag, beats), 32'(pmem_error), 32'(eerr));
                if (eerr) chk($sformatf("%s_rd%0d", tag, beats), pmem_rdata, 32'h0);
                else if (nbeats == 8)
                    chk($sformatf("%s_rd%0d", tag, beats), pmem_rdata, eline[beats*32 +: 32]);
                beats++;
            end else begin
                chk($sformatf("%s_idle_rd", tag), pmem_rdata, 32'h0);
                chk($sformatf("%s_idle_err", tag), 32'(pmem_error), 32'h0);
                if (beats > 0) done = 1'b1;
            end
        end
        if (!done) chk($sformatf("%s_timeout", tag), 32'h1, 32'h0);
        chk($sformatf("%s_beats", tag), 32'(beats), 32'(nbeats));
        if (!hold) begin
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
        end
    endtask

    initial begin
        l0     = mkline(32'hA5A50000, 32'h1);
        l2     = mkline(32'h11111111, 32'h11111111);
        l2_new = mkline(32'hDEAD0000, 32'h3);
        l5     = mkline(32'h50505050, 32'h01010101);
        junk   = mkline(32'hBAD00000, 32'h7);

        rst = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        pmem_address = '0;
        pmem_wdata = '0;
        #1;
        chk("rst_resp", 32'(pmem_resp), 32'h0);
        chk("rst_err", 32'(pmem_error), 32'h0);
        chk("rst_rdata", pmem_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Request in the very first cycle after reset release.
        xact(1'b0, 1'b1, 32'h0, l0, 1, 1'b0, '0, FIRST, 1'b0, "wr_l0");
        @(negedge clk); xact(1'b1, 1'b0, 32'h0, '0, 8, 1'b0, l0, FIRST, 1'b0, "rd_l0");

        // Write/read of address 0x40 (line 2).
        @(negedge clk); xact(1'b0, 1'b1, 32'h40, l2, 1, 1'b0, '0, FIRST, 1'b0, "wr_l2");
        @(negedge clk); xact(1'b1, 1'b0, 32'h40, '0, 8, 1'b0, l2, FIRST, 1'b0, "rd_l2");

        // Out-of-range read, then line 0 intact.
        @(negedge clk); xact(1'b1, 1'b0, 32'h800, '0, 1, 1'b1, '0, FIRST, 1'b0, "rd_oor");
        @(negedge clk); xact(1'b1, 1'b0, 32'h0, '0, 8, 1'b0, l0, FIRST, 1'b0, "rd_l0_b");

        // Out-of-range write whose low index bits alias line 0: no store.
        @(negedge clk); xact(1'b0, 1'b1, 32'h8000_0000, junk, 1, 1'b1, '0, FIRST, 1'b0, "wr_oor");
        @(negedge clk); xact(1'b1, 1'b0, 32'h0, '0, 8, 1'b0, l0, FIRST, 1'b0, "rd_l0_c");

        // Read and write together: error, no store.
        @(negedge clk); xact(1'b1, 1'b1, 32'h0, junk, 1, 1'b1, '0, FIRST, 1'b0, "rdwr");
        @(negedge clk); xact(1'b1, 1'b0, 32'h0, '0, 8, 1'b0, l0, FIRST, 1'b0, "rd_l0_d");

        // Reset during read beat 3, request still held through release.
        @(negedge clk);
        pmem_read = 1'b1;
        pmem_address = 32'h40;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (pmem_resp) n++;
        end
        chk("beat3_reach", 32'(n), 32'h4);
        #1 rst = 1'b1;
        #1;
        chk("rstb3_resp", 32'(pmem_resp), 32'h0);
        chk("rstb3_err", 32'(pmem_error), 32'h0);
        chk("rstb3_rdata", pmem_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        xact(1'b1, 1'b0, 32'h40, '0, 8, 1'b0, l2, FIRST, 1'b0, "rd_after_rst");

        // Reset during WAIT of a write to line 2: storage untouched.
        @(negedge clk);
        pmem_write = 1'b1;
        pmem_address = 32'h40;
        pmem_wdata = l2_new;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rstw_resp", 32'(pmem_resp), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pmem_write = 1'b0;
        @(negedge clk); xact(1'b1, 1'b0, 32'h40, '0, 8, 1'b0, l2, FIRST, 1'b0, "rd_l2_kept");

        // Back-to-back write then read, requests held; read captured right after GAP.
        @(negedge clk); xact(1'b0, 1'b1, 32'hA0, l5, 1, 1'b0, '0, FIRST, 1'b1, "b2b_wr");
        xact(1'b1, 1'b0, 32'hA0, '0, 8, 1'b0, l5, FIRST + 1, 1'b0, "b2b_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
